axis_udp_rx_adapter: RTL
========================

// Module: axis_udp_rx_adapter
// PURPOSE
// - Upstream stage of the UDP filter: AXI-Stream slave to filter word interface (frame/en/last).
// - Reorders bytes so byte 0 of each beat sits at frame_o[DATA_WIDTH-1 -: 8].
// - Zeroes bytes with tkeep low, truncates oversize frames, stalls upstream between frames.
// - The filter has no backpressure; this block is the flow-control point of the receive path.
// PARAMETERS
// - DATA_WIDTH       64  beat width in bits, multiple of 8
// - MAX_FRAME_WORDS  190 max beats per frame incl. last; beat MAX_FRAME_WORDS is forced last
// - MIN_FRAME_WORDS  5   frames with fewer beats raise err_runt_o (still forwarded)
// - MIN_GAP          2   idle cycles forced after every frame_last_o, >= 1
// PORTS
// - clk_i           in   1             clock
// - a_rst_n_i       in   1             reset, asynchronous, active-low
// - en_i            in   1             block enable, sampled only in IDLE
// - s_axis_tdata    in   DATA_WIDTH    beat data, byte 0 at [7:0]
// - s_axis_tkeep    in   DATA_WIDTH/8  byte qualifiers
// - s_axis_tvalid   in   1             beat valid
// - s_axis_tlast    in   1             last beat of frame
// - s_axis_tready   out  1             beat accept
// - hold_i          in   1             downstream busy; 1 holds the next frame off
// - frame_o         out  DATA_WIDTH    reordered beat data -> filter frame_i
// - en_o            out  1             frame_o valid for one cycle -> filter en_i
// - frame_last_o    out  1             qualifies en_o; last beat -> filter frame_last_i
// - err_oversize_o  out  1             1-cycle pulse, frame truncated
// - err_runt_o      out  1             1-cycle pulse, with frame_last_o of a short frame
// BEHAVIOUR
// - Reset: every output 0, s_axis_tready 0; word_cnt 0, gap_cnt 0; FSM in IDLE.
// - Accept = s_axis_tvalid & s_axis_tready. tready is combinational from state and en_i only.
// - Outputs registered: 1 cycle latency from accept to en_o. en_o is 0 on cycles with no accept.
// - Byte map: frame_o[DATA_WIDTH-1-8k -: 8] = tkeep[k] ? tdata[8k+7 : 8k] : 8'h00.
// - word_cnt counts accepted beats of the current frame. Width $clog2(MAX_FRAME_WORDS+1).
//   Cleared on every exit to GAP.
// - FSM:
//   - IDLE: tready = en_i. On accept, forward the beat; word_cnt = 1.
//     tlast -> GAP (1-beat frame, err_runt_o if MIN_FRAME_WORDS > 1). Else -> PASS.
//   - PASS: tready = 1. Forward each accepted beat.
//     On tlast: frame_last_o = 1; err_runt_o if word_cnt+1 < MIN_FRAME_WORDS; -> GAP.
//     On the beat that makes word_cnt+1 == MAX_FRAME_WORDS without tlast:
//     frame_last_o = 1, err_oversize_o = 1, -> DROP.
//     If tlast and the max-count beat coincide: normal last, no error.
//   - DROP: tready = 1. Discard beats, en_o stays 0. Accepted tlast -> GAP.
//   - GAP: tready = 0. Count MIN_GAP cycles, then -> HOLD.
//   - HOLD: tready = 0. When hold_i == 0 -> IDLE.
//     A frame is never started while hold_i == 1.
// - en_i low mid-frame: has no effect; the current frame completes normally.
// - tvalid gaps within a frame: allowed; en_o gaps follow them.
// - Reset mid-frame: async clear; no frame_last_o is emitted for the partial frame.
//   Upstream must restart the frame.
// CONFIGURATION
// - Macro: AXIS_UDP_RX_ADAPTER_STATS_EN.
// - Defined:
//   - Adds outputs frame_cnt_o [31:0] and drop_cnt_o [31:0].
//   - frame_cnt_o += 1 on every frame_last_o.
//   - drop_cnt_o += 1 on every err_oversize_o.
//   - Both counters wrap at 2^32, reset to 0, and hold while a_rst_n_i is low.
// - Undefined: neither port nor the counters exist; all other behaviour is identical.
// STRUCTURE
// - Package udp_pkg: rx_adapter_state_t enum {IDLE, PASS, DROP, GAP, HOLD};
//   ETHERTYPE_IPV4 16'h0800; IPV4_VERSION 4'h4; PROTOCOL_UDP 8'h11.
//   The UDP filter imports the same package.
// - Sub-module axis_byte_reorder: combinational tkeep masking plus byte reversal,
//   parameterised on DATA_WIDTH.
// - The FSM, counters and output registers live in the top level.
// TESTING
// 1. 6-beat frame, tkeep all 1, byte k = k:
//    - en_o six cycles, each 1 cycle after its accept.
//    - First frame_o = 64'h0001020304050607.
//    - frame_last_o only on beat 6; no errors.
// 2. Last beat with tkeep = 8'h0F, tdata = 64'hFFFF_FFFF_AABB_CCDD:
//    - frame_o = 64'hDDCC_BBAA_0000_0000 with frame_last_o = 1.
// 3. MAX_FRAME_WORDS = 8, 12-beat frame:
//    - 8 en_o; the 8th carries frame_last_o and err_oversize_o.
//    - Beats 9-12 accepted with no en_o; then GAP.
//    - drop_cnt_o = 1 when STATS_EN is defined.
// 4. 3-beat frame:
//    - err_runt_o with frame_last_o on beat 3.
//    - tready = 0 for exactly MIN_GAP = 2 cycles, then high again with hold_i = 0.
// 5. hold_i = 1 for 20 cycles after a frame:
//    - tready stays 0 until the cycle after hold_i falls.
//    - The back-to-back next frame is not accepted early.
// 6. a_rst_n_i low during beat 3 of a frame:
//    - All outputs 0 immediately.
//    - After release, a new frame starts from IDLE and word_cnt restarts at 1.

Source files
------------

// File: rtl/udp_pkg.sv
// udp_pkg: types and constants shared by the UDP receive adapter and filter.
// Holds the adapter FSM state type and the header field constants.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    DROP,
    GAP,
    HOLD
  } rx_adapter_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IPV4_VERSION   = 4'h4;
  localparam logic [7:0]  PROTOCOL_UDP   = 8'h11;

endpackage

// File: rtl/axis_byte_reorder.sv
// axis_byte_reorder: zeroes bytes whose keep bit is low and reverses byte order.
// Ports: data/keep in, swapped out; byte 0 of data lands in the top byte of swapped.
module axis_byte_reorder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] keep,
  output logic [DATA_WIDTH-1:0]   swapped
);

  always_comb begin
    swapped = '0;
    for (int k = 0; k < DATA_WIDTH / 8; k++) begin
      swapped[DATA_WIDTH-1-8*k -: 8] =
        keep[k] ? data[8*k +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/axis_udp_rx_adapter.sv
// axis_udp_rx_adapter: AXI-Stream slave to filter word interface (frame/en/last).
// Ports: clk_i, a_rst_n_i, en_i, s_axis_*, hold_i in; frame_o, en_o, frame_last_o,
// err_oversize_o, err_runt_o out; frame_cnt_o/drop_cnt_o with AXIS_UDP_RX_ADAPTER_STATS_EN.
module axis_udp_rx_adapter
  import udp_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_FRAME_WORDS = 190,
  parameter int MIN_FRAME_WORDS = 5,
  parameter int MIN_GAP         = 2
) (
  input  logic                    clk_i,
  input  logic                    a_rst_n_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    hold_i,
  output logic [DATA_WIDTH-1:0]   frame_o,
  output logic                    en_o,
  output logic                    frame_last_o,
  output logic                    err_oversize_o,
  output logic                    err_runt_o
`ifdef AXIS_UDP_RX_ADAPTER_STATS_EN
  ,
  output logic [31:0]             frame_cnt_o,
  output logic [31:0]             drop_cnt_o
`endif
);

  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CW-1:0] MAX_W = CW'(MAX_FRAME_WORDS);
  localparam logic [CW-1:0] MIN_W = CW'(MIN_FRAME_WORDS);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

  rx_adapter_state_t state, state_nx;
  logic [CW-1:0] word_cnt, word_cnt_nx, cnt_inc;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic [DATA_WIDTH-1:0] swapped;
  logic accept, fwd, last, ovs, runt;

  axis_byte_reorder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reorder (
    .data    (s_axis_tdata),
    .keep    (s_axis_tkeep),
    .swapped (swapped)
  );

  // Reset term keeps tready low while the block is held in reset.
  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state)
      IDLE:       s_axis_tready = en_i;
      PASS, DROP: s_axis_tready = 1'b1;
      default:    s_axis_tready = 1'b0;
    endcase
    s_axis_tready = s_axis_tready & a_rst_n_i;
  end

  assign accept = s_axis_tvalid & s_axis_tready;
  // Beat number of the beat currently on the bus.
  assign cnt_inc = (state == IDLE) ? CW'(1) : word_cnt + CW'(1);

  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    gap_cnt_nx  = gap_cnt;
    fwd         = 1'b0;
    last        = 1'b0;
    ovs         = 1'b0;
    runt        = 1'b0;
    unique case (state)
      IDLE, PASS: begin
        if (accept) begin
          fwd = 1'b1;
          if (s_axis_tlast) begin
            last        = 1'b1;
            runt        = cnt_inc < MIN_W;
            word_cnt_nx = '0;
            state_nx    = GAP;
          end else if (cnt_inc == MAX_W) begin
            last        = 1'b1;
            ovs         = 1'b1;
            word_cnt_nx = cnt_inc;
            state_nx    = DROP;
          end else begin
            word_cnt_nx = cnt_inc;
            state_nx    = PASS;
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) begin
          word_cnt_nx = '0;
          state_nx    = GAP;
        end
      end
      GAP: begin
        // The last gap cycle already checks hold_i so an idle
        // downstream sees exactly MIN_GAP stalled cycles.
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = '0;
          state_nx   = hold_i ? HOLD : IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GW'(1);
        end
      end
      HOLD: begin
        if (!hold_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state          <= IDLE;
      word_cnt       <= '0;
      gap_cnt        <= '0;
      frame_o        <= '0;
      en_o           <= 1'b0;
      frame_last_o   <= 1'b0;
      err_oversize_o <= 1'b0;
      err_runt_o     <= 1'b0;
    end else begin
      state          <= state_nx;
      word_cnt       <= word_cnt_nx;
      gap_cnt        <= gap_cnt_nx;
      frame_o        <= fwd ? swapped : '0;
      en_o           <= fwd;
      frame_last_o   <= last;
      err_oversize_o <= ovs;
      err_runt_o     <= runt;
    end
  end

`ifdef AXIS_UDP_RX_ADAPTER_STATS_EN
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (frame_last_o)   frame_cnt_o <= frame_cnt_o + 32'd1;
      if (err_oversize_o) drop_cnt_o  <= drop_cnt_o + 32'd1;
    end
  end
`endif

endmodule
